// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter between CPU fetch and a boot loader/debug port.
// Define IMEM_ARB_RR_EN for round-robin contention in RUN; default is loader priority.
module imem_arbiter #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          cpu_stall,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  input  logic          l_done,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          boot_mode,
  output logic [AW:0]   load_cnt
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic        gnt_f, gnt_l, contested;
  logic        f_rvalid_q, l_rvalid_q;
  logic [AW:0] cnt_q;

`ifdef IMEM_ARB_RR_EN
  logic        rr_last_l;
`endif

  // Grants are combinational so a lone requester is served in the same cycle.
  always_comb begin
    state_d   = state_q;
    gnt_f     = 1'b0;
    gnt_l     = 1'b0;
    contested = 1'b0;
    if (rst_n) begin
      case (state_q)
        BOOT: begin
          gnt_l = l_req;
          if (l_done) state_d = RUN;
        end
        RUN: begin
          contested = f_req & l_req;
          if (contested) begin
`ifdef IMEM_ARB_RR_EN
            gnt_f = rr_last_l;
            gnt_l = ~rr_last_l;
`else
            gnt_l = 1'b1;
`endif
          end else begin
            gnt_f = f_req;
            gnt_l = l_req;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= gnt_f;
      l_rvalid_q <= gnt_l & ~l_we;
      // The top bit set means the count has reached 2^AW and holds there.
      if (gnt_l && l_we && !cnt_q[AW])
        cnt_q <= cnt_q + (AW+1)'(1);
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Remembers who won the last contested cycle; reset favours fetch next.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_last_l <= 1'b1;
    else if (contested)
      rr_last_l <= gnt_l;
  end
`endif

  assign f_gnt     = gnt_f;
  assign l_gnt     = gnt_l;
  assign cpu_stall = f_req & ~gnt_f;

  assign m_en    = gnt_f | gnt_l;
  assign m_we    = gnt_l & l_we;
  assign m_addr  = gnt_l ? l_addr[AW+1:2] : f_addr[AW+1:2];
  assign m_wdata = gnt_l ? l_wdata : 32'h0;

  // A read landing while reset is held is dropped rather than reported.
  assign f_rvalid = f_rvalid_q & rst_n;
  assign l_rvalid = l_rvalid_q & rst_n;
  assign f_rdata  = f_rvalid ? m_rdata : 32'h0;
  assign l_rdata  = l_rvalid ? m_rdata : 32'h0;

  assign boot_mode = (state_q == BOOT);
  assign load_cnt  = cnt_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a behavioural 1-cycle-latency memory.
// Expected values follow IMEM_ARB_RR_EN when that macro is defined.
module tb_imem_arbiter;

  logic        clk, rst_n;
  logic        f_req, f_gnt, cpu_stall, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_gnt, l_rvalid, l_done;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_en, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        boot_mode;
  logic [8:0]  load_cnt;

  int checks = 0;
  int errors = 0;

  imem_arbiter #(.AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .cpu_stall(cpu_stall),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_done(l_done),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .boot_mode(boot_mode), .load_cnt(load_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:255];

  // Synchronous-read single-port memory standing in for the real IMEM.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  typedef struct {
    logic        rst_n, f_req;
    logic [31:0] f_addr;
    logic        l_req, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        l_done;
    logic        e_fg, e_lg, e_stall, e_men, e_mwe;
    logic [7:0]  e_maddr;
    logic [31:0] e_mwdata;
    logic        e_frv;
    logic [31:0] e_frd;
    logic        e_lrv;
    logic [31:0] e_lrd;
    logic        e_boot;
    logic [8:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic rs, input logic fq, input logic [31:0] fa,
                               input logic lq, input logic lw, input logic [31:0] la,
                               input logic [31:0] ld, input logic dn);
    @(negedge clk);
    rst_n = rs; f_req = fq; f_addr = fa;
    l_req = lq; l_we = lw; l_addr = la; l_wdata = ld; l_done = dn;
    #1;
  endtask

  task automatic checkVal(input string name, input int row, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, row, act, exp);
    end
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    checkVal("f_gnt",     row, {31'b0, f_gnt},     {31'b0, v.e_fg});
    checkVal("l_gnt",     row, {31'b0, l_gnt},     {31'b0, v.e_lg});
    checkVal("cpu_stall", row, {31'b0, cpu_stall}, {31'b0, v.e_stall});
    checkVal("m_en",      row, {31'b0, m_en},      {31'b0, v.e_men});
    checkVal("m_we",      row, {31'b0, m_we},      {31'b0, v.e_mwe});
    if (v.e_men) checkVal("m_addr",  row, {24'b0, m_addr}, {24'b0, v.e_maddr});
    if (v.e_mwe) checkVal("m_wdata", row, m_wdata, v.e_mwdata);
    checkVal("f_rvalid",  row, {31'b0, f_rvalid},  {31'b0, v.e_frv});
    checkVal("f_rdata",   row, f_rdata,            v.e_frd);
    checkVal("l_rvalid",  row, {31'b0, l_rvalid},  {31'b0, v.e_lrv});
    checkVal("l_rdata",   row, l_rdata,            v.e_lrd);
    checkVal("boot_mode", row, {31'b0, boot_mode}, {31'b0, v.e_boot});
    checkVal("load_cnt",  row, {23'b0, load_cnt},  {23'b0, v.e_cnt});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    m_rdata = 32'h0;
    rst_n = 1'b0; f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; l_done = 1'b0;

    // Fields: rst_n f_req f_addr l_req l_we l_addr l_wdata l_done | fg lg stall men mwe maddr mwdata frv frd lrv lrd boot cnt
    vecs.push_back('{1'b0,1'b1,32'h0,  1'b1,1'b1,32'h0,32'h11111111,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b1,9'd0});
    vecs.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b1,9'd0});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b1,32'h0,32'h8C010000,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b1,8'h0,32'h8C010000, 1'b0,32'h0,1'b0,32'h0,1'b1,9'd0});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b1,32'h4,32'h00211020,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b1,8'h1,32'h00211020, 1'b0,32'h0,1'b0,32'h0,1'b1,9'd1});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b0,32'h0,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b1,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b1,32'h8C010000,1'b1,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h4,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h1,32'h0,        1'b1,32'h8C010000,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h0,32'h0,        1'b1,32'h00211020,1'b0,32'h0,1'b0,9'd2});
`ifdef IMEM_ARB_RR_EN
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b0,32'h4,32'h0,       1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b0,32'h4,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,8'h1,32'h0,        1'b1,32'h8C010000,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b0,32'h4,32'h0,       1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b1,32'h00211020,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b0,32'h4,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,8'h1,32'h0,        1'b1,32'h8C010000,1'b0,32'h0,1'b0,9'd2});
`else
    vecs.push_back('{1'b1,1'b1,32'h0,  1'b1,1'b0,32'h4,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,8'h1,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b0,9'd2});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b1,1'b1,32'h0,1'b1,1'b0,32'h4,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,8'h1,32'h0,        1'b0,32'h0,1'b1,32'h00211020,1'b0,9'd2});
`endif
    vecs.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b1,32'h00211020,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h403,1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h0,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h0,32'h0,        1'b1,32'h8C010000,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b0,32'h0,  1'b1,1'b1,32'h8,32'hDEADBEEF,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b1,8'h2,32'hDEADBEEF, 1'b0,32'h0,1'b0,32'h0,1'b0,9'd2});
    vecs.push_back('{1'b1,1'b1,32'h8,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,8'h2,32'h0,        1'b0,32'h0,1'b0,32'h0,1'b0,9'd3});
    vecs.push_back('{1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,32'h0,       1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,8'h0,32'h0,        1'b1,32'hDEADBEEF,1'b0,32'h0,1'b0,9'd3});

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req,
                    vecs[i].l_we, vecs[i].l_addr, vecs[i].l_wdata, vecs[i].l_done);
      checkOutput(i, vecs[i]);
    end

    // 300 loader writes starting from a count of 3: the count must stop at 256.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 32'(i), 1'b0);
      if (i == 253) begin
        checkVal("sat_reach_cnt", 1000 + i, {23'b0, load_cnt}, 32'd256);
        checkVal("sat_reach_gnt", 1000 + i, {31'b0, l_gnt}, 32'd1);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkVal("sat_hold_cnt", 2000, {23'b0, load_cnt}, 32'd256);

    // A read granted just before reset must never report rvalid.
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkVal("rst_rd_gnt", 3000, {31'b0, f_gnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkVal("rst_rd_rvalid", 3001, {31'b0, f_rvalid}, 32'd0);
    checkVal("rst_rd_rdata", 3001, f_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkVal("rst_after_rvalid", 3002, {31'b0, f_rvalid}, 32'd0);
    checkVal("rst_after_boot", 3002, {31'b0, boot_mode}, 32'd1);
    checkVal("rst_after_cnt", 3002, {23'b0, load_cnt}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkVal("rst_boot_fgnt", 3003, {31'b0, f_gnt}, 32'd0);
    checkVal("rst_boot_stall", 3003, {31'b0, cpu_stall}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning word-address width; memory depth is 2^AW words of 32 bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port f_req, input, 1, CPU fetch read request.
REQ-005 The block SHALL have port f_addr, input, 32, fetch byte address; bits [AW+1:2] used.
REQ-006 The block SHALL have ports f_gnt, output, 1 (fetch accepted this cycle), and cpu_stall, output, 1 (equals f_req AND NOT f_gnt).
REQ-007 The block SHALL have ports f_rvalid, output, 1, and f_rdata, output, 32, the fetch read return.
REQ-008 The block SHALL have ports l_req, input, 1; l_we, input, 1; l_addr, input, 32; l_wdata, input, 32 (loader/debug requester).
REQ-009 The block SHALL have ports l_gnt, output, 1; l_rvalid, output, 1; l_rdata, output, 32; l_done, input, 1 (end-of-boot pulse).
REQ-010 The block SHALL have ports m_en, output, 1; m_we, output, 1; m_addr, output, AW; m_wdata, output, 32; m_rdata, input, 32 (single-port synchronous-read memory, 1-cycle read latency).
REQ-011 The block SHALL have ports boot_mode, output, 1, and load_cnt, output, AW+1, count of accepted loader writes.

Function
REQ-012 The FSM SHALL have two states: BOOT (reset state) and RUN.
REQ-013 In BOOT, f_gnt SHALL be 0; l_gnt SHALL equal l_req.
REQ-014 BOOT->RUN SHALL occur on the edge where l_done=1; a loader request in that same cycle is still granted and completed.
REQ-015 RUN SHALL be terminal until reset; l_done in RUN is ignored.
REQ-016 In RUN with only one requester active, that requester SHALL be granted in the same cycle (combinational grant).
REQ-017 In RUN with both active, arbitration SHALL follow REQ-027/028; exactly one grant per cycle, never both.
REQ-018 m_en SHALL equal (f_gnt OR l_gnt); m_addr, m_we, m_wdata SHALL be driven from the granted requester; m_we=0 for fetch grants.
REQ-019 Address bits above AW+1 SHALL be ignored (wrap-around); bits [1:0] ignored.
REQ-020 A granted read SHALL produce the owner's rvalid=1 exactly one cycle later with rdata=m_rdata; a granted write produces no rvalid.
REQ-021 rvalid outputs SHALL be registered one-cycle pulses; back-to-back grants yield back-to-back rvalids.
REQ-022 When not asserting rvalid, f_rdata/l_rdata SHALL read 0.
REQ-023 load_cnt SHALL increment on each granted loader write and saturate at 2^AW.
REQ-024 boot_mode SHALL be 1 in BOOT, 0 in RUN.

Reset
REQ-025 On rst_n=0 at a clock edge: state=BOOT, f_rvalid=0, l_rvalid=0, load_cnt=0, round-robin pointer = loader; reads in flight are discarded (no rvalid follows).
REQ-026 While rst_n=0, f_gnt, l_gnt, m_en, m_we SHALL be 0 regardless of requests.

Configuration
REQ-027 With macro IMEM_ARB_RR_EN defined, RUN contention SHALL be round-robin: the requester not granted in the last contested cycle wins; pointer updates only on contested cycles.
REQ-028 Without IMEM_ARB_RR_EN, RUN contention SHALL be fixed priority: loader always wins, fetch stalls.

Verification
REQ-029 Reset, no requests -> boot_mode=1, all grants/rvalids 0, load_cnt=0.
REQ-030 BOOT: loader writes 0x8C010000 @0x0, 0x00211020 @0x4, f_req=1 throughout -> f_gnt=0, cpu_stall=1, load_cnt=2; l_done -> next cycle boot_mode=0, fetch @0x0 granted, f_rvalid next cycle with f_rdata=0x8C010000.
REQ-031 RUN, contested every cycle for 4 cycles: RR_EN -> grants alternate fetch,loader,fetch,loader (pointer=loader after reset, so first contest goes to fetch); no RR_EN -> loader x4, cpu_stall=1 x4.
REQ-032 Fetch @0x400 -> m_addr=0 (wrap); 300 loader writes -> load_cnt saturates at 256.
REQ-033 rst_n=0 one cycle after granted read -> no rvalid, state=BOOT, load_cnt=0.
